bcd_updown_counter: RTL and testbench

- Parametrised successor to the team's 4-bit presettable down counter: a cascaded multi-digit modulo-BASE up/down counter.
- Adds selectable direction, wrap/saturate mode, input clamping on load, a registered wrap pulse and a zero flag.
- Used as the game-side timer and score counter; the CO output cascades into further instances, 74161-style.

---
 rtl/bcd_updown_counter.sv | 90 +++++++++
 tb/tb_bcd_updown_counter.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/bcd_updown_counter.sv
// Cascadable multi-digit modulo-BASE up/down counter with clamped parallel load,
// wrap/saturate selection, a registered wrap pulse and a zero flag.
module bcd_updown_counter #(
    parameter int                     DIGITS    = 2,
    parameter int                     DW        = 4,
    parameter int                     BASE      = 10,
    parameter logic [DIGITS*DW-1:0]   RESET_VAL = 8'h05
) (
    input  logic                 CP,
    input  logic                 CR,
    input  logic                 Ld,
    input  logic                 CTP,
    input  logic                 CTT,
    input  logic                 UD,
    input  logic                 SAT,
    input  logic [DIGITS*DW-1:0] D,
    output logic [DIGITS*DW-1:0] Q,
    output logic                 CO,
    output logic                 WRAP,
    output logic                 ZERO
);

    localparam int            W    = DIGITS * DW;
    localparam logic [DW-1:0] MAXD = DW'(BASE - 1);

    logic [W-1:0] q_inc;
    logic [W-1:0] q_dec;
    logic [W-1:0] d_clamped;
    logic         term_up;
    logic         term_dn;
    logic         term;
    logic         cnt_en;
    logic         carry;
    logic         borrow;

    // Digit-wise ripple: each digit only moves when every lower digit rolls over.
    // NOTE: always_comb gives every output a default first, so no latch can be inferred.
    always_comb begin
        q_inc     = Q;
        q_dec     = Q;
        d_clamped = D;
        carry     = 1'b1;
        borrow    = 1'b1;
        term_up   = 1'b1;
        term_dn   = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                q_inc[i*DW +: DW] = (Q[i*DW +: DW] == MAXD) ? '0 : Q[i*DW +: DW] + 1'b1;
            end
            if (borrow) begin
                q_dec[i*DW +: DW] = (Q[i*DW +: DW] == '0) ? MAXD : Q[i*DW +: DW] - 1'b1;
            end
            carry   = carry  & (Q[i*DW +: DW] == MAXD);
            borrow  = borrow & (Q[i*DW +: DW] == '0);
            term_up = term_up & (Q[i*DW +: DW] == MAXD);
            term_dn = term_dn & (Q[i*DW +: DW] == '0);
            // Widen by one bit so BASE == 2**DW compares correctly.
            if ({1'b0, D[i*DW +: DW]} >= (DW+1)'(BASE)) begin
                d_clamped[i*DW +: DW] = MAXD;
            end
        end
    end

    assign term   = UD ? term_up : term_dn;
    assign cnt_en = CTP & CTT;
    assign CO     = CTT & term;
    assign ZERO   = (Q == '0);

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge CP or posedge CR) begin
        if (CR) begin
            Q    <= RESET_VAL;
            WRAP <= 1'b0;
        end else if (!Ld) begin
            Q    <= d_clamped;
            WRAP <= 1'b0;
        end else if (cnt_en) begin
            if (term && SAT) begin
                WRAP <= 1'b0;
            end else begin
                // The ripple from the terminal state lands exactly on the wrapped value.
                Q    <= UD ? q_inc : q_dec;
                WRAP <= term;
            end
        end else begin
            WRAP <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed self-checking bench for bcd_updown_counter at DIGITS=2, DW=4, BASE=10.
module tb_bcd_updown_counter;

    logic       CP = 1'b0;
    logic       CR = 1'b0;
    logic       Ld = 1'b1;
    logic       CTP = 1'b0;
    logic       CTT = 1'b0;
    logic       UD = 1'b1;
    logic       SAT = 1'b0;
    logic [7:0] D = 8'h00;
    logic [7:0] Q;
    logic       CO;
    logic       WRAP;
    logic       ZERO;

    int n_vec = 0;
    int n_err = 0;

    bcd_updown_counter #(
        .DIGITS    (2),
        .DW        (4),
        .BASE      (10),
        .RESET_VAL (8'h05)
    ) dut (
        .CP   (CP),
        .CR   (CR),
        .Ld   (Ld),
        .CTP  (CTP),
        .CTT  (CTT),
        .UD   (UD),
        .SAT  (SAT),
        .D    (D),
        .Q    (Q),
        .CO   (CO),
        .WRAP (WRAP),
        .ZERO (ZERO)
    );

    always #5 CP = ~CP;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge CP);
        #1;
    endtask

    // Check Q, CO, WRAP, ZERO together.
    task automatic chk4(input string tag, input logic [7:0] q, input logic co,
                        input logic wr, input logic z);
        check({tag, ".q"},    32'(Q),    32'(q));
        check({tag, ".co"},   32'(CO),   32'(co));
        check({tag, ".wrap"}, 32'(WRAP), 32'(wr));
        check({tag, ".zero"}, 32'(ZERO), 32'(z));
    endtask

    task automatic load(input logic [7:0] v);
        Ld = 1'b0;
        D  = v;
        step();
        Ld = 1'b1;
    endtask

    initial begin
        // Asynchronous reset between edges
        step();
        #2;
        CR = 1'b1;
        UD = 1'b1;
        CTT = 1'b1;
        #1;
        chk4("rst_async", 8'h05, 1'b0, 1'b0, 1'b0);
        // Reset overrides load and count
        Ld = 1'b0; D = 8'h33; CTP = 1'b1;
        step();
        step();
        check("rst_hold.q", 32'(Q), 32'h05);
        Ld = 1'b1; CTP = 1'b0;
        #2;
        CR = 1'b0;

        // Up count with wrap
        step();
        check("hold_after_rst.q", 32'(Q), 32'h05);
        SAT = 1'b0; UD = 1'b1; CTP = 1'b1; CTT = 1'b1;
        load(8'h97);
        chk4("ld97", 8'h97, 1'b0, 1'b0, 1'b0);
        step(); chk4("up98", 8'h98, 1'b0, 1'b0, 1'b0);
        step(); chk4("up99", 8'h99, 1'b1, 1'b0, 1'b0);
        step(); chk4("up00", 8'h00, 1'b0, 1'b1, 1'b1);
        step(); chk4("up01", 8'h01, 1'b0, 1'b0, 1'b0);

        // Up ripple across a digit
        load(8'h19);
        step(); check("up20.q", 32'(Q), 32'h20);

        // Down count, saturate at zero
        load(8'h10);
        check("ld10.q", 32'(Q), 32'h10);
        UD = 1'b0; SAT = 1'b1;
        step(); chk4("dn09", 8'h09, 1'b0, 1'b0, 1'b0);
        step(); check("dn08.q", 32'(Q), 32'h08);
        step(); check("dn07.q", 32'(Q), 32'h07);
        load(8'h01);
        step(); chk4("dn00", 8'h00, 1'b1, 1'b0, 1'b1);
        step(); chk4("sat00a", 8'h00, 1'b1, 1'b0, 1'b1);
        step(); chk4("sat00b", 8'h00, 1'b1, 1'b0, 1'b1);

        // Down wrap, then combinational CO on UD flip
        SAT = 1'b0;
        step(); chk4("dnwrap", 8'h99, 1'b0, 1'b1, 1'b0);
        UD = 1'b1;
        #1;
        check("co_ud_flip", 32'(CO), 32'h1);

        // Hold with CTP=0, then CO gated by CTT
        CTP = 1'b0;
        step(); chk4("hold_ctp0", 8'h99, 1'b1, 1'b0, 1'b0);
        CTT = 1'b0;
        #1;
        check("co_ctt0", 32'(CO), 32'h0);
        step(); check("hold_ctt0.q", 32'(Q), 32'h99);

        // Up saturate at 99
        CTP = 1'b1; CTT = 1'b1; SAT = 1'b1;
        step(); chk4("sat99", 8'h99, 1'b1, 1'b0, 1'b0);

        // Clamped load beats count
        load(8'h42);
        check("ld42.q", 32'(Q), 32'h42);
        load(8'hAF);
        check("ld_clampAF.q", 32'(Q), 32'h99);
        load(8'h3C);
        check("ld_clamp3C.q", 32'(Q), 32'h39);
        load(8'hB2);
        check("ld_clampB2.q", 32'(Q), 32'h92);

        // Reset mid-count, resume from RESET_VAL
        SAT = 1'b0; UD = 1'b1;
        step();
        check("cnt93.q", 32'(Q), 32'h93);
        #2;
        CR = 1'b1;
        #1;
        check("rst_mid.q", 32'(Q), 32'h05);
        #2;
        CR = 1'b0;
        step();
        check("resume06.q", 32'(Q), 32'h06);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
